// File: rtl/ah_snoopable_fifo_param_if.sv
// Bundle of the FIFO write, read, snoop and status signals.
// The FIFO takes the slave side, and the request producer/consumer takes the master side.
interface ah_snoopable_fifo_param_if #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEPTH       = 20,
    parameter int unsigned SNOOP_WIDTH = 16
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]       wdata;
    logic                   wvalid;
    logic                   wready;
    logic [WIDTH-1:0]       rdata;
    logic                   rvalid;
    logic                   rready;
    logic [SNOOP_WIDTH-1:0] sdata;
    logic                   svalid;
    logic                   sresp_valid;
    logic                   smatch;
    logic [CW-1:0]          smatch_cnt;
    logic [CW-1:0]          smatch_pos;
    logic [CW-1:0]          count;
    logic                   almost_full;

    modport slave (
        input  wdata, wvalid, rready, sdata, svalid,
        output wready, rdata, rvalid, sresp_valid, smatch, smatch_cnt, smatch_pos,
               count, almost_full
    );

    modport master (
        output wdata, wvalid, rready, sdata, svalid,
        input  wready, rdata, rvalid, sresp_valid, smatch, smatch_cnt, smatch_pos,
               count, almost_full
    );
endinterface

// File: rtl/ah_snoopable_fifo_param.sv
// This is a first-word-fall-through FIFO of any depth with a registered associative snoop.
// The snoop compares only occupied entries. It returns a match flag, the match count
// and the position of the oldest match, measured from the head.
module ah_snoopable_fifo_param #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEPTH        = 20,
    parameter int unsigned SNOOP_WIDTH  = 16,
    parameter int unsigned AFULL_THRESH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    ah_snoopable_fifo_param_if.slave   bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;

    logic             sresp_valid_q;
    logic             smatch_q;
    logic [CW-1:0]    smatch_cnt_q;
    logic [CW-1:0]    smatch_pos_q;

    logic             wready_c;
    logic             rvalid_c;
    logic             wfire_c;
    logic             rfire_c;
    logic             hit_c;
    logic [CW-1:0]    hit_cnt_c;
    logic [CW-1:0]    hit_pos_c;

    // Pointers wrap explicitly so that non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Handshake and status are derived from the occupancy register.
    assign wready_c = (count_q != CW'(DEPTH));
    assign rvalid_c = (count_q != '0);
    assign wfire_c  = bus.wvalid && wready_c;
    assign rfire_c  = rvalid_c && bus.rready;

    assign bus.wready      = wready_c;
    assign bus.rvalid      = rvalid_c;
    assign bus.rdata       = mem[rd_ptr];
    assign bus.count       = count_q;
    assign bus.almost_full = (count_q >= CW'(AFULL_THRESH));
    assign bus.sresp_valid = sresp_valid_q;
    assign bus.smatch      = smatch_q;
    assign bus.smatch_cnt  = smatch_cnt_q;
    assign bus.smatch_pos  = smatch_pos_q;

    // Walk the entries from the head so that the first hit gives the oldest position.
    // Offsets at or beyond count are stale and are never compared.
    always_comb begin
        int idx;
        idx       = 0;
        hit_c     = 1'b0;
        hit_cnt_c = '0;
        hit_pos_c = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            idx = int'(rd_ptr) + k;
            if (idx >= int'(DEPTH)) begin
                idx = idx - int'(DEPTH);
            end
            if ((k < int'(count_q)) && (mem[PW'(idx)][SNOOP_WIDTH-1:0] == bus.sdata)) begin
                if (!hit_c) begin
                    hit_pos_c = CW'(k);
                end
                hit_c     = 1'b1;
                hit_cnt_c = hit_cnt_c + CW'(1);
            end
        end
    end

    // Update the pointers, the occupancy and the registered snoop result.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count_q       <= '0;
            sresp_valid_q <= 1'b0;
            smatch_q      <= 1'b0;
            smatch_cnt_q  <= '0;
            smatch_pos_q  <= '0;
        end else begin
            if (wfire_c) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rfire_c) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({wfire_c, rfire_c})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            sresp_valid_q <= bus.svalid;
            if (bus.svalid) begin
                smatch_q     <= hit_c;
                smatch_cnt_q <= hit_cnt_c;
                smatch_pos_q <= hit_pos_c;
            end
        end
    end

    // Storage is not reset. A write in a reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (!rst && wfire_c) begin
            mem[wr_ptr] <= bus.wdata;
        end
    end
endmodule

// File: tb/tb_ah_snoopable_fifo_param.sv
// Scoreboard bench for ah_snoopable_fifo_param.
// The driver keeps a queue model of the FIFO and pushes the expected results.
// A monitor on the falling edge pops those results and compares them with the DUT.
module tb_ah_snoopable_fifo_param;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 20;
    localparam int unsigned SW    = 16;
    localparam int unsigned AF    = 16;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic          m;
        logic [CW-1:0] cnt;
        logic [CW-1:0] pos;
    } snoop_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ah_snoopable_fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SNOOP_WIDTH(SW)) bus ();

    ah_snoopable_fifo_param #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .SNOOP_WIDTH(SW), .AFULL_THRESH(AF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] model_q [$];
    logic [WIDTH-1:0] rd_q [$];
    snoop_t           sn_q [$];
    int               st_q [$];
    int               n_checks = 0;
    int               n_pass   = 0;
    bit               armed    = 1'b0;
    snoop_t           last_sn  = '0;
    snoop_t           got_sn;
    int               exp_cnt;
    logic [63:0]      exp64;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Snoop result computed directly from the list of queued words.
    function automatic snoop_t ref_snoop(input logic [SW-1:0] key);
        snoop_t r;
        int     n;
        int     first;
        logic [WIDTH-1:0] w;
        n     = 0;
        first = -1;
        for (int k = 0; k < model_q.size(); k++) begin
            w = model_q[k];
            if (w[SW-1:0] == key) begin
                if (first < 0) first = k;
                n++;
            end
        end
        r.m   = (n > 0);
        r.cnt = CW'(n);
        r.pos = (first < 0) ? '0 : CW'(first);
        return r;
    endfunction

    // Drive one cycle and record in the scoreboard what the DUT must show.
    task automatic cycle(input bit wv, input logic [WIDTH-1:0] wd, input bit rr,
                         input bit sv, input logic [SW-1:0] sd, input bit rs);
        bit wf;
        bit rf;
        @(posedge clk);
        #1;
        rst        = rs;
        bus.wvalid = wv;
        bus.wdata  = wd;
        bus.rready = rr;
        bus.svalid = sv;
        bus.sdata  = sd;
        if (!rs) armed = 1'b1;
        if (armed) st_q.push_back(model_q.size());
        if (rs) begin
            model_q.delete();
        end else begin
            wf = wv && (model_q.size() < int'(DEPTH));
            rf = rr && (model_q.size() > 0);
            if (rf) rd_q.push_back(model_q[0]);
            if (sv) sn_q.push_back(ref_snoop(sd));
            if (rf) void'(model_q.pop_front());
            if (wf) model_q.push_back(wd);
        end
    endtask

    function automatic logic [SW-1:0] pick_key();
        case ($urandom_range(0, 3))
            0:       return 16'h1234;
            1:       return 16'h5555;
            2:       return 16'h7777;
            default: return 16'($urandom);
        endcase
    endfunction

    // Monitor: compare status, popped data and snoop results against the scoreboard.
    always @(negedge clk) begin
        if (armed) begin
            exp_cnt = (st_q.size() != 0) ? st_q.pop_front() : -1;
            check("count", 64'(bus.count), 64'(exp_cnt));
            check("wready", 64'(bus.wready), 64'(exp_cnt != int'(DEPTH)));
            check("rvalid", 64'(bus.rvalid), 64'(exp_cnt != 0));
            check("almost_full", 64'(bus.almost_full), 64'(exp_cnt >= int'(AF)));
            if (bus.rvalid && bus.rready) begin
                exp64 = (rd_q.size() != 0) ? 64'(rd_q.pop_front()) : 64'hBAD0_0000_0000;
                check("rdata", 64'(bus.rdata), exp64);
            end
            got_sn = {bus.smatch, bus.smatch_cnt, bus.smatch_pos};
            if (bus.sresp_valid) begin
                if (sn_q.size() != 0) begin
                    last_sn = sn_q.pop_front();
                    exp64   = 64'(last_sn);
                end else begin
                    exp64 = 64'hFFFF_FFFF_FFFF_FFFF;
                end
                check("snoop_result", 64'(got_sn), exp64);
            end else begin
                check("snoop_hold", 64'(got_sn), 64'(last_sn));
            end
            if (rst) last_sn = '0;
        end
    end

    initial begin
        bit               wv;
        bit               rr;
        bit               sv;
        bit               rs;
        int               wp;
        int               rp;
        bus.wvalid = 1'b0;
        bus.wdata  = '0;
        bus.rready = 1'b0;
        bus.svalid = 1'b0;
        bus.sdata  = '0;
        cycle(0, '0, 0, 0, '0, 1);
        cycle(0, '0, 0, 0, '0, 1);

        // Fill to full, reject an extra write, then drain in order and read once past empty.
        for (int i = 0; i < 20; i++) cycle(1, 32'h100 + 32'(i), 0, 0, '0, 0);
        cycle(1, 32'hDEAD, 0, 0, '0, 0);
        for (int i = 0; i < 21; i++) cycle(0, '0, 1, 0, '0, 0);

        // When the FIFO is full, a write and a read in the same cycle: only the read fires.
        for (int i = 0; i < 20; i++) cycle(1, 32'h200 + 32'(i), 0, 0, '0, 0);
        cycle(1, 32'h300, 1, 0, '0, 0);
        cycle(1, 32'h300, 0, 0, '0, 0);
        for (int i = 0; i < 20; i++) cycle(0, '0, 1, 0, '0, 0);

        // Snoop with two matches, then pop two entries and snoop again.
        cycle(1, 32'h0000AAAA, 0, 0, '0, 0);
        cycle(1, 32'h00001234, 0, 0, '0, 0);
        cycle(1, 32'h00005555, 0, 0, '0, 0);
        cycle(1, 32'hFFFF1234, 0, 0, '0, 0);
        cycle(0, '0, 0, 1, 16'h1234, 0);
        cycle(0, '0, 1, 0, '0, 0);
        cycle(0, '0, 1, 0, '0, 0);
        cycle(0, '0, 0, 1, 16'h1234, 0);
        cycle(0, '0, 1, 0, '0, 0);
        cycle(0, '0, 1, 0, '0, 0);

        // Stale data must not match. A write in the same cycle as a snoop is not visible to it.
        cycle(1, 32'h00007777, 0, 0, '0, 0);
        cycle(0, '0, 1, 0, '0, 0);
        cycle(0, '0, 0, 1, 16'h7777, 0);
        cycle(1, 32'h00007777, 0, 1, 16'h7777, 0);
        cycle(0, '0, 0, 1, 16'h7777, 0);
        cycle(0, '0, 1, 1, 16'h7777, 0);
        cycle(0, '0, 0, 1, 16'h7777, 0);

        // Random traffic: the write and read biases alternate to reach both full and empty.
        for (int ph = 0; ph < 4; ph++) begin
            wp = (ph % 2 == 0) ? 75 : 35;
            rp = (ph % 2 == 0) ? 35 : 75;
            for (int i = 0; i < 120; i++) begin
                wv = ($urandom_range(0, 99) < wp);
                rr = ($urandom_range(0, 99) < rp);
                sv = ($urandom_range(0, 99) < 40);
                rs = ($urandom_range(0, 299) == 0);
                cycle(wv, {16'($urandom), pick_key()}, rr, sv, pick_key(), rs);
            end
        end

        // Reset arrives mid-operation along with a write and a snoop. Both are discarded.
        for (int i = 0; i < 20; i++) cycle(0, '0, 1, 0, '0, 0);
        for (int i = 0; i < 10; i++) cycle(1, 32'h400 + 32'(i), 0, 0, '0, 0);
        cycle(1, 32'h0000BEEF, 0, 1, 16'hBEEF, 1);
        cycle(0, '0, 1, 0, '0, 0);
        cycle(0, '0, 0, 1, 16'hBEEF, 0);
        cycle(1, 32'h00000500, 0, 0, '0, 0);
        cycle(0, '0, 1, 1, 16'h0500, 0);
        cycle(0, '0, 1, 0, '0, 0);

        for (int i = 0; i < 3; i++) cycle(0, '0, 0, 0, '0, 0);
        @(negedge clk);
        #1;
        check("rd_queue_left", 64'(rd_q.size()), 64'(0));
        check("snoop_queue_left", 64'(sn_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
